// File: rtl/de0_nano_system_timer_host.sv
// de0_nano_system_timer_host: Avalon-MM master that programs, runs and services an interval timer
module de0_nano_system_timer_host #(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       period,
  input  logic              stop_req,
  input  logic              snap_req,
  output logic [2:0]        tm_address,
  output logic              tm_chipselect,
  output logic              tm_write_n,
  output logic [15:0]       tm_writedata,
  input  logic [15:0]       tm_readdata,
  input  logic              tm_irq,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid
);
  typedef enum logic [3:0] {
    IDLE, CFG_STOP, CFG_PL, CFG_PH, CFG_CLR, CFG_RUN, RUN, ACK,
    SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP, HALT_STOP, HALT_CLR
  } state_t;
  state_t state_q, state_d;
  logic [31:0] period_q, period_d;
  logic [2:0] addr_q, addr_d;
  logic cs_q, cs_d;
  logic [15:0] wd_q, wd_d;
  logic tick_q, tick_d;
  logic [TICK_W-1:0] tick_count_q, tick_count_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_value_q, snap_value_d;
  logic snap_valid_q, snap_valid_d;
  logic stop_pending_q, stop_pending_d;
  logic snap_pending_q, snap_pending_d;
  logic accept, stop_any, snap_any;
  assign accept = state_q == IDLE && start;
  assign stop_any = stop_pending_q || stop_req;
  assign snap_any = snap_pending_q || snap_req;
  // next state: a fresh stop/snap request counts in RUN so stop beats a same-cycle irq
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = start ? CFG_STOP : IDLE;
      CFG_STOP:  state_d = CFG_PL;
      CFG_PL:    state_d = CFG_PH;
      CFG_PH:    state_d = CFG_CLR;
      CFG_CLR:   state_d = CFG_RUN;
      CFG_RUN:   state_d = RUN;
      RUN:       state_d = stop_any ? HALT_STOP : tm_irq ? ACK : snap_any ? SNAP_WR : RUN;
      ACK:       state_d = RUN;
      SNAP_WR:   state_d = SNAP_RL;
      SNAP_RL:   state_d = SNAP_RH;
      SNAP_RH:   state_d = SNAP_CAP;
      SNAP_CAP:  state_d = RUN;
      HALT_STOP: state_d = HALT_CLR;
      HALT_CLR:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // bus access decoded from the next state so the registered bus lines up with state_q
  always_comb begin
    addr_d = 3'd0;
    wd_d = 16'h0000;
    case (state_d)
      CFG_STOP, HALT_STOP: begin addr_d = 3'd1; wd_d = 16'h0008; end
      CFG_PL:              begin addr_d = 3'd2; wd_d = period_q[15:0]; end
      CFG_PH:              begin addr_d = 3'd3; wd_d = period_q[31:16]; end
      CFG_RUN:             begin addr_d = 3'd1; wd_d = 16'h0007; end
      SNAP_WR, SNAP_RL:    addr_d = 3'd4;
      SNAP_RH:             addr_d = 3'd5;
      default:             ;
    endcase
    cs_d = state_d inside {CFG_STOP, CFG_PL, CFG_PH, CFG_CLR, CFG_RUN, ACK, SNAP_WR, HALT_STOP, HALT_CLR};
  end
  // datapath: period latch, tick counting, snapshot capture and pending requests
  always_comb begin
    period_d = accept ? period : period_q;
    tick_d = state_d == ACK;
    tick_count_d = accept ? '0 : tick_d ? tick_count_q + TICK_W'(1) : tick_count_q;
    snap_lo_d = state_q == SNAP_RH ? tm_readdata : snap_lo_q;
    snap_value_d = state_q == SNAP_CAP ? {tm_readdata, snap_lo_q} : snap_value_q;
    snap_valid_d = state_q == SNAP_CAP;
    stop_pending_d = state_q == HALT_CLR ? 1'b0 : stop_pending_q || (stop_req && state_q != IDLE);
    snap_pending_d = state_q == HALT_CLR ? 1'b0 :
                     (snap_pending_q && state_q != SNAP_WR) || (snap_req && state_q != IDLE);
  end
  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      period_q <= '0;
      addr_q <= '0;
      cs_q <= 1'b0;
      wd_q <= '0;
      tick_q <= 1'b0;
      tick_count_q <= '0;
      snap_lo_q <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
      stop_pending_q <= 1'b0;
      snap_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      period_q <= period_d;
      addr_q <= addr_d;
      cs_q <= cs_d;
      wd_q <= wd_d;
      tick_q <= tick_d;
      tick_count_q <= tick_count_d;
      snap_lo_q <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      stop_pending_q <= stop_pending_d;
      snap_pending_q <= snap_pending_d;
    end
  end
  assign tm_address = addr_q;
  assign tm_chipselect = cs_q;
  assign tm_write_n = !cs_q;
  assign tm_writedata = wd_q;
  assign busy = state_q != IDLE;
  assign running = state_q inside {RUN, ACK, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP};
  assign tick = tick_q;
  assign tick_count = tick_count_q;
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
endmodule

// File: tb/tb_de0_nano_system_timer_host.sv
// tb_de0_nano_system_timer_host: directed bench with a small interval-timer slave model
module tb_de0_nano_system_timer_host;
  localparam int TW = 4;
  logic clk, reset_n, start, stop_req, snap_req, tm_irq;
  logic [31:0] period, snap_value;
  logic [2:0] tm_address;
  logic tm_chipselect, tm_write_n, busy, running, tick, snap_valid;
  logic [15:0] tm_writedata, tm_readdata;
  logic [TW-1:0] tick_count;
  logic fire;
  logic [31:0] snap_src, snap_lat;
  int n_vec = 0, n_bad = 0, cyc = 0, ticks = 0, valids = 0;
  int base, c0, t0, v0;
  logic [2:0] wa[$];
  logic [15:0] wdq[$];
  int wc[$];

  de0_nano_system_timer_host #(.TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .period(period),
    .stop_req(stop_req), .snap_req(snap_req), .tm_address(tm_address),
    .tm_chipselect(tm_chipselect), .tm_write_n(tm_write_n), .tm_writedata(tm_writedata),
    .tm_readdata(tm_readdata), .tm_irq(tm_irq), .busy(busy), .running(running),
    .tick(tick), .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // timer slave: irq held until status written, snapshot latched on addr4 write, registered reads
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm_irq <= 1'b0;
      tm_readdata <= 16'h0;
      snap_lat <= 32'h0;
    end else begin
      if (tm_chipselect && !tm_write_n && tm_address == 3'd0) tm_irq <= 1'b0;
      else if (fire) tm_irq <= 1'b1;
      if (tm_chipselect && !tm_write_n && tm_address == 3'd4) snap_lat <= snap_src;
      tm_readdata <= tm_address == 3'd4 ? snap_lat[15:0] : tm_address == 3'd5 ? snap_lat[31:16] : 16'h0;
    end
  end

  // bus write log and pulse counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tm_chipselect && !tm_write_n) begin
      wa.push_back(tm_address);
      wdq.push_back(tm_writedata);
      wc.push_back(cyc);
    end
    if (tick) ticks <= ticks + 1;
    if (snap_valid) valids <= valids + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_check(input string tag, input logic [31:0] p, input int b, input int c);
    logic [2:0] ea[5];
    logic [15:0] ed[5];
    ea[0] = 3'd1; ea[1] = 3'd2; ea[2] = 3'd3; ea[3] = 3'd0; ea[4] = 3'd1;
    ed[0] = 16'h0008; ed[1] = p[15:0]; ed[2] = p[31:16]; ed[3] = 16'h0000; ed[4] = 16'h0007;
    chk({tag, " count"}, wa.size() - b, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s w%0d", tag, i), {13'(wc[b+i] - c), wa[b+i], wdq[b+i]}, {13'(i + 1), ea[i], ed[i]});
  endtask

  initial begin
    reset_n = 0; start = 0; period = 0; stop_req = 0; snap_req = 0; fire = 0; snap_src = 0;
    step(3);
    chk("rst bus", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
    chk("rst status", {busy, running, tick, snap_valid, 4'(tick_count)}, 8'h00);
    chk("rst snap", snap_value, 32'h0);
    reset_n = 1;
    step(2);
    // start programs period and runs
    base = wa.size(); c0 = cyc;
    start = 1; period = 32'h0001_3880;
    step;
    start = 0; period = 0;
    chk("t1 busy", busy, 1);
    step(5);
    cfg_check("t1", 32'h0001_3880, base, c0);
    chk("t1 run", {busy, running}, 2'b11);
    // three timeouts, one tick each
    base = wa.size();
    for (int k = 1; k <= 3; k++) begin
      fire = 1; step; fire = 0;
      chk("t2 pre tick", tick, 0);
      step;
      chk("t2 tick", tick, 1);
      chk("t2 count", tick_count, 32'(k));
      chk("t2 ack bus", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd0, 16'h0});
      step;
      chk("t2 no extra", tick, 0);
      step(2);
    end
    chk("t2 ticks", ticks, 3);
    chk("t2 writes", wa.size() - base, 3);
    // snapshot
    snap_src = 32'h0000_A5C3;
    snap_req = 1; step; snap_req = 0;
    chk("t3 wr", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd4, 16'h0});
    step;
    chk("t3 rl", {tm_chipselect, tm_write_n, tm_address}, {1'b0, 1'b1, 3'd4});
    step;
    chk("t3 rh", {tm_chipselect, tm_write_n, tm_address}, {1'b0, 1'b1, 3'd5});
    step;
    chk("t3 early valid", snap_valid, 0);
    step;
    chk("t3 valid", snap_valid, 1);
    chk("t3 value", snap_value, 32'h0000_A5C3);
    step;
    chk("t3 valid pulse", snap_valid, 0);
    // start while running is ignored; snapshot requested during ACK follows it
    base = wa.size();
    start = 1; period = 32'h0000_0005; step; start = 0;
    step(3);
    chk("t6 no cfg", wa.size() - base, 0);
    chk("t6 busy", busy, 1);
    snap_src = 32'hBEEF_1234;
    fire = 1; step; fire = 0;
    step;
    chk("t6 tick", tick, 1);
    snap_req = 1; step; snap_req = 0;
    chk("t6 run gap", {tick, tm_chipselect}, 2'b00);
    step;
    chk("t6 snap wr", {tm_chipselect, tm_write_n, tm_address}, {1'b1, 1'b0, 3'd4});
    step(4);
    chk("t6 valid", snap_valid, 1);
    chk("t6 value", snap_value, 32'hBEEF_1234);
    chk("t6 count", tick_count, 4);
    // tick_count wraps from all-ones
    for (int i = 0; i < 11; i++) begin
      fire = 1; step; fire = 0; step(3);
    end
    chk("wrap max", tick_count, 4'hF);
    fire = 1; step; fire = 0; step;
    chk("wrap zero", {tick, 4'(tick_count)}, {1'b1, 4'h0});
    step(2);
    // stop and irq (and a snapshot request) in the same RUN cycle
    t0 = ticks; v0 = valids;
    fire = 1; step; fire = 0;
    stop_req = 1; snap_req = 1; step; stop_req = 0; snap_req = 0;
    chk("t4 stop wr", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd1, 16'h0008});
    step;
    chk("t4 clr wr", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd0, 16'h0});
    step;
    chk("t4 idle", {busy, running}, 2'b00);
    step(6);
    chk("t4 no tick", ticks - t0, 0);
    chk("t4 no snap", valids - v0, 0);
    chk("t4 count", tick_count, 0);
    // stop in IDLE ignored; second start during config ignored
    stop_req = 1; step; stop_req = 0; step;
    base = wa.size(); c0 = cyc;
    start = 1; period = 32'h89AB_CDEF; step;
    period = 32'h1111_1111; step; start = 0; period = 0;
    step(4);
    cfg_check("t7", 32'h89AB_CDEF, base, c0);
    step(3);
    chk("t7 still run", busy, 1);
    stop_req = 1; step; stop_req = 0;
    step(2);
    chk("t7 stopped", busy, 0);
    // reset during CFG_PH
    start = 1; period = 32'h0F0F_A0A0; step; start = 0;
    step(2);
    chk("t5 ph", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd3, 16'h0F0F});
    reset_n = 0;
    #1;
    chk("t5 async", {tm_chipselect, tm_write_n, busy}, 3'b010);
    step(2);
    reset_n = 1;
    step;
    chk("t5 bus idle", {tm_chipselect, tm_write_n, tm_address, busy}, {1'b0, 1'b1, 3'd0, 1'b0});
    base = wa.size(); c0 = cyc;
    start = 1; period = 32'h0F0F_A0A0; step; start = 0;
    step(5);
    cfg_check("t5", 32'h0F0F_A0A0, base, c0);
    chk("t5 run", running, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
